pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter NFWD, default 2, number of downstream forwarding stages (1..4; stage 1 = EXE).
REQ-002 Parameter MDU_LAT, default 8, cycles from multi-cycle op issue to result writeback (2..31).
REQ-003 Parameter AW, default 5, register address width; register 0 is hardwired zero.
REQ-004 clk  input  1  the single clock; reset is synchronous and active-high.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 id_rs, id_rt  input  AW each  decode-stage source addresses.
REQ-007 id_rs_used, id_rt_used  input  1 each  decode instruction reads that source.
REQ-008 id_wreg, id_waddr  input  1, AW  decode instruction writes register id_waddr.
REQ-009 id_mdu  input  1  decode instruction is a multi-cycle (mul/div) op.
REQ-010 id_branch, id_taken  input  1 each  decode holds a branch/jump; branch resolved taken.
REQ-011 st_wreg, st_mem2reg  input  NFWD each  per-stage write-enable and load flags, bit k-1 = stage k.
REQ-012 st_waddr  input  NFWD*AW  per-stage destination addresses, packed, stage 1 in LSBs.
REQ-013 fwda, fwdb  output  3 each  operand source: 0 = register file, k = stage k.
REQ-014 stall  output  1  hold IF/ID, insert bubble into EXE.
REQ-015 flush  output  1  squash the instruction in IF.
REQ-016 mdu_busy  output  1  multi-cycle unit occupied.

Function
REQ-017 Forwarding SHALL be combinational: for each used source with nonzero address, select the lowest k where st_wreg[k-1] and st_waddr[k]==source; otherwise 0.
REQ-018 Load-use: source matching stage 1 with st_mem2reg[0]=1 SHALL assert stall for exactly one cycle; rs and rt SHALL be checked independently, not if/else-chained.
REQ-019 Scoreboard: one pending bit per register; set on the cycle a non-stalled id_mdu with id_wreg issues; cleared when the MDU countdown reaches 0.
REQ-020 Decode reading a pending register, or writing one (WAW), SHALL stall until the bit clears.
REQ-021 MDU countdown SHALL load MDU_LAT on issue, decrement each cycle, and drive mdu_busy while nonzero; id_mdu while busy SHALL stall.
REQ-022 FSM states: IDLE, MDU_BUSY, FLUSH; IDLE->MDU_BUSY on issue; MDU_BUSY->IDLE when count==1 and no new issue; any state->FLUSH on an unstalled taken branch; FLUSH->IDLE or MDU_BUSY (by mdu_busy) next cycle.
REQ-023 flush SHALL be high exactly one cycle, only in FLUSH; untaken branches SHALL cause neither stall nor flush.
REQ-024 Simultaneous stall and taken branch: stall wins, flush deferred until the branch is re-presented unstalled.
REQ-025 Stall sources SHALL be ORed; stall SHALL block scoreboard set and branch flush that cycle.
REQ-026 Writes to register 0 SHALL never set pending nor cause hazards.

Reset
REQ-027 On rst: FSM=IDLE, scoreboard all zero, countdown 0, stall=0, flush=0, mdu_busy=0; in-flight MDU op is abandoned.
REQ-028 rst asserted mid-MDU_BUSY SHALL clear busy in the following cycle with no residual stall.

Configuration
REQ-029 Macro PCPU_HAZARD_PERF_EN: when defined, add 32-bit saturating counters perf_loaduse, perf_mdu, perf_flush (outputs) incremented per cycle of each cause, cleared by rst.
REQ-030 Without PCPU_HAZARD_PERF_EN the counters and ports SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package pcpu_hazard_pkg SHALL hold the FSM state enum, FWD_RF=0 constant, and the fwd select width.
REQ-032 Sub-module mdu_scoreboard SHALL contain the pending bits and countdown; FSM and forwarding stay in the top.

Verification
REQ-033 Stage 2 writes r5 (no load), decode add r6,r5,r5 -> fwda=2, fwdb=2, stall=0.
REQ-034 Stage 1 lw r3, decode uses rt=r3 only -> stall=1 one cycle, then fwdb=2 next cycle.
REQ-035 MDU_LAT=8, issue mul to r9, next decode reads r9 -> stall 8 cycles, mdu_busy falls same cycle stall drops.
REQ-036 Taken beq with no hazard -> flush=1 one cycle, stall=0; untaken -> flush=0.
REQ-037 Taken beq whose rs is a stage-1 load -> stall first, flush on following cycle.
REQ-038 rst at cycle 3 of an MDU op -> mdu_busy=0, scoreboard empty, no stall next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pcpu_hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   FWD_W      : width of an operand forwarding select
//   fwd_sel_t  : forwarding select (0 = register file, k = pipeline stage k)
//   FWD_RF     : select value meaning "take the register file"
//   hz_state_t : hazard FSM state encoding
//   sat_inc32  : 32-bit saturating increment used by the optional counters
// ----------------------------------------------------------------------------
package pcpu_hazard_pkg;

    localparam int FWD_W = 3;

    typedef logic [FWD_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MDU_BUSY = 2'd1,
        ST_FLUSH    = 2'd2
    } hz_state_t;

    // Counter that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   Decode stage  : id_rs/id_rt (+ _used), id_wreg/id_waddr, id_mdu,
//                   id_branch/id_taken
//   Later stages  : st_wreg, st_mem2reg (bit k-1 = stage k),
//                   st_waddr (packed, stage 1 in the LSBs)
//   Controls back : fwda, fwdb, stall, flush, mdu_busy
//   Optional      : perf_loaduse, perf_mdu, perf_flush when
//                   PCPU_HAZARD_PERF_EN is defined
// Modports: master = datapath side, slave = hazard controller.
// ----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if import pcpu_hazard_pkg::*; #(
    parameter int NFWD = 2,
    parameter int AW   = 5
) ();

    logic [AW-1:0]      id_rs;
    logic [AW-1:0]      id_rt;
    logic               id_rs_used;
    logic               id_rt_used;
    logic               id_wreg;
    logic [AW-1:0]      id_waddr;
    logic               id_mdu;
    logic               id_branch;
    logic               id_taken;
    logic [NFWD-1:0]    st_wreg;
    logic [NFWD-1:0]    st_mem2reg;
    logic [NFWD*AW-1:0] st_waddr;

    fwd_sel_t           fwda;
    fwd_sel_t           fwdb;
    logic               stall;
    logic               flush;
    logic               mdu_busy;

`ifdef PCPU_HAZARD_PERF_EN
    logic [31:0]        perf_loaduse;
    logic [31:0]        perf_mdu;
    logic [31:0]        perf_flush;

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_waddr,
               id_mdu, id_branch, id_taken, st_wreg, st_mem2reg, st_waddr,
        input  fwda, fwdb, stall, flush, mdu_busy,
               perf_loaduse, perf_mdu, perf_flush
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_waddr,
               id_mdu, id_branch, id_taken, st_wreg, st_mem2reg, st_waddr,
        output fwda, fwdb, stall, flush, mdu_busy,
               perf_loaduse, perf_mdu, perf_flush
    );
`else
    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_waddr,
               id_mdu, id_branch, id_taken, st_wreg, st_mem2reg, st_waddr,
        input  fwda, fwdb, stall, flush, mdu_busy
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_waddr,
               id_mdu, id_branch, id_taken, st_wreg, st_mem2reg, st_waddr,
        output fwda, fwdb, stall, flush, mdu_busy
    );
`endif

endinterface

// File: rtl/pipe_hazard_ctrl_mdu_scoreboard.sv
// ----------------------------------------------------------------------------
// mdu_scoreboard
// Tracks the single in-flight multi-cycle (mul/div) operation: a countdown
// from issue to writeback and one pending bit per architectural register.
//   clk, rst     : clock, synchronous active-high reset (abandons the op)
//   issue        : an MDU op leaves decode this cycle (already unstalled)
//   issue_wreg   : that op writes a register
//   issue_waddr  : its destination register
//   pending      : per-register "result not yet written back"
//   busy         : countdown nonzero (unit occupied)
//   last         : countdown is 1, the op writes back at this edge
//   busy_next    : unit will still be occupied after this edge
// ----------------------------------------------------------------------------
module mdu_scoreboard #(
    parameter int MDU_LAT = 8,
    parameter int AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              issue_wreg,
    input  logic [AW-1:0]     issue_waddr,
    output logic [2**AW-1:0]  pending,
    output logic              busy,
    output logic              last,
    output logic              busy_next
);

    localparam int NREG  = 2**AW;
    localparam int CNT_W = $clog2(MDU_LAT + 1);

    logic [CNT_W-1:0] count_q,   count_d;
    logic [NREG-1:0]  pending_q, pending_d;
    logic [AW-1:0]    dest_q,    dest_d;

    always_comb begin
        // NOTE: every variable is given its hold value first, so no path can leave it unassigned and infer a latch.
        count_d   = count_q;
        pending_d = pending_q;
        dest_d    = dest_q;

        if (count_q != '0) begin
            count_d = count_q - 1'b1;
            // Writeback happens as the count reaches zero.
            if (count_q == CNT_W'(1)) begin
                pending_d[dest_q] = 1'b0;
            end
        end

        // Issue is only possible while idle (a busy unit stalls id_mdu), so
        // the load never collides with an outstanding op.
        if (issue) begin
            count_d = CNT_W'(MDU_LAT);
            dest_d  = '0;
            // Register 0 is hardwired zero and is never marked pending.
            if (issue_wreg && (issue_waddr != '0)) begin
                pending_d[issue_waddr] = 1'b1;
                dest_d                 = issue_waddr;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: pending is a flop vector rather than a RAM, so it is reset along with the rest of the state.
        if (rst) begin
            count_q   <= '0;
            pending_q <= '0;
            dest_q    <= '0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            dest_q    <= dest_d;
        end
    end

    assign pending   = pending_q;
    assign busy      = (count_q != '0);
    assign last      = (count_q == CNT_W'(1));
    assign busy_next = (count_d != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for an in-order pipeline: operand forwarding selects,
// load-use and multi-cycle-unit stalls, and branch flush.
//   clk, rst : clock, synchronous active-high reset
//   hz       : pipe_hazard_ctrl_if.slave (decode/stage info in,
//              fwda/fwdb/stall/flush/mdu_busy out)
// Parameters: NFWD forwarding stages (1..4), MDU_LAT issue-to-writeback
// latency (2..31), AW register address width.
// Optional: define PCPU_HAZARD_PERF_EN to add saturating 32-bit counters
// perf_loaduse / perf_mdu / perf_flush on the interface.
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl import pcpu_hazard_pkg::*; #(
    parameter int NFWD    = 2,
    parameter int MDU_LAT = 8,
    parameter int AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int NREG = 2**AW;

    // Lowest (youngest) matching stage wins; scanning downward lets the
    // last assignment be the lowest k.
    function automatic fwd_sel_t fwd_pick(
        input logic               used,
        input logic [AW-1:0]      src,
        input logic [NFWD-1:0]    wreg,
        input logic [NFWD*AW-1:0] waddr
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (used && (src != '0)) begin
            for (int k = NFWD; k >= 1; k--) begin
                if (wreg[k-1] && (waddr[(k-1)*AW +: AW] == src)) begin
                    sel = fwd_sel_t'(k);
                end
            end
        end
        return sel;
    endfunction

    logic [NREG-1:0] pending;
    logic            mdu_busy;
    logic            mdu_last;
    logic            mdu_busy_next;
    logic            stage1_load;
    logic            lu_rs, lu_rt;
    logic            sb_rs, sb_rt, sb_waw, mdu_struct;
    logic            stall_loaduse, stall_mdu, stall;
    logic            issue, br_taken;
    hz_state_t       state_q;

    // Only a stage-1 load is too late to forward; deeper loads already
    // have their data, so the other mem2reg bits are informational.
    logic unused_mem2reg;
    assign unused_mem2reg = ^hz.st_mem2reg;

    assign hz.fwda = fwd_pick(hz.id_rs_used, hz.id_rs, hz.st_wreg, hz.st_waddr);
    assign hz.fwdb = fwd_pick(hz.id_rt_used, hz.id_rt, hz.st_wreg, hz.st_waddr);

    // Load-use: rs and rt are evaluated independently and ORed.
    assign stage1_load = hz.st_wreg[0] && hz.st_mem2reg[0];
    assign lu_rs = stage1_load && hz.id_rs_used && (hz.id_rs != '0) &&
                   (hz.st_waddr[AW-1:0] == hz.id_rs);
    assign lu_rt = stage1_load && hz.id_rt_used && (hz.id_rt != '0) &&
                   (hz.st_waddr[AW-1:0] == hz.id_rt);

    // Scoreboard hazards: RAW on a pending result, WAW on a pending
    // destination, and a structural hazard on the single MDU.
    assign sb_rs      = hz.id_rs_used && (hz.id_rs != '0) && pending[hz.id_rs];
    assign sb_rt      = hz.id_rt_used && (hz.id_rt != '0) && pending[hz.id_rt];
    assign sb_waw     = hz.id_wreg && (hz.id_waddr != '0) && pending[hz.id_waddr];
    assign mdu_struct = hz.id_mdu && mdu_busy;

    assign stall_loaduse = lu_rs || lu_rt;
    assign stall_mdu     = sb_rs || sb_rt || sb_waw || mdu_struct;
    assign stall         = !rst && (stall_loaduse || stall_mdu);

    // A stalled decode does nothing: no MDU issue, no branch redirect. A
    // stalled taken branch is simply seen again once the stall clears.
    assign issue    = hz.id_mdu && !stall;
    assign br_taken = hz.id_branch && hz.id_taken && !stall;

    mdu_scoreboard #(
        .MDU_LAT (MDU_LAT),
        .AW      (AW)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .issue_wreg  (hz.id_wreg),
        .issue_waddr (hz.id_waddr),
        .pending     (pending),
        .busy        (mdu_busy),
        .last        (mdu_last),
        .busy_next   (mdu_busy_next)
    );

    // flush is decoded straight from the state register, so it is a
    // registered, one-cycle pulse per accepted taken branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (br_taken) begin
            state_q <= ST_FLUSH;
        end else begin
            unique case (state_q)
                ST_IDLE:     if (issue) state_q <= ST_MDU_BUSY;
                ST_MDU_BUSY: if (mdu_last && !issue) state_q <= ST_IDLE;
                ST_FLUSH:    state_q <= mdu_busy_next ? ST_MDU_BUSY : ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    assign hz.stall    = stall;
    assign hz.flush    = (state_q == ST_FLUSH);
    assign hz.mdu_busy = mdu_busy;

`ifdef PCPU_HAZARD_PERF_EN
    logic [31:0] perf_loaduse_q, perf_loaduse_d;
    logic [31:0] perf_mdu_q,     perf_mdu_d;
    logic [31:0] perf_flush_q,   perf_flush_d;

    assign perf_loaduse_d = sat_inc32(perf_loaduse_q, stall_loaduse);
    assign perf_mdu_d     = sat_inc32(perf_mdu_q, stall_mdu);
    assign perf_flush_d   = sat_inc32(perf_flush_q, hz.flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_loaduse_q <= '0;
            perf_mdu_q     <= '0;
            perf_flush_q   <= '0;
        end else begin
            perf_loaduse_q <= perf_loaduse_d;
            perf_mdu_q     <= perf_mdu_d;
            perf_flush_q   <= perf_flush_d;
        end
    end

    assign hz.perf_loaduse = perf_loaduse_q;
    assign hz.perf_mdu     = perf_mdu_q;
    assign hz.perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Driver pushes the expected per-cycle response into a queue; a monitor on
// the falling edge pops and compares. Directed steps push hand-derived
// values; random steps push values from a behavioural model that tracks the
// MDU as "cycles left + destination register" and the branch as "flush due".
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int NFWD    = 2;
    localparam int MDU_LAT = 8;
    localparam int AW      = 5;

    typedef struct {
        logic               rst;
        logic [AW-1:0]      rs;
        logic [AW-1:0]      rt;
        logic               rs_used;
        logic               rt_used;
        logic               wreg;
        logic [AW-1:0]      waddr;
        logic               mdu;
        logic               branch;
        logic               taken;
        logic [NFWD-1:0]    st_wreg;
        logic [NFWD-1:0]    st_mem2reg;
        logic [NFWD*AW-1:0] st_waddr;
    } stim_t;

    typedef struct {
        string tag;
        int    fwda;
        int    fwdb;
        int    stall;
        int    flush;
        int    busy;
    } exp_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    // Reference model state.
    int   m_busy_left = 0;
    int   m_pend_reg  = -1;
    int   m_flush_due = 0;

    pipe_hazard_ctrl_if #(.NFWD(NFWD), .AW(AW)) hif ();

    pipe_hazard_ctrl #(
        .NFWD    (NFWD),
        .MDU_LAT (MDU_LAT),
        .AW      (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s.rst = 1'b0; s.rs = '0; s.rt = '0; s.rs_used = 1'b0; s.rt_used = 1'b0;
        s.wreg = 1'b0; s.waddr = '0; s.mdu = 1'b0; s.branch = 1'b0; s.taken = 1'b0;
        s.st_wreg = '0; s.st_mem2reg = '0; s.st_waddr = '0;
        return s;
    endfunction

    function automatic stim_t with_stage(input stim_t s, input int k, input int addr, input bit load);
        stim_t r;
        r = s;
        r.st_wreg[k-1]              = 1'b1;
        r.st_mem2reg[k-1]           = load;
        r.st_waddr[(k-1)*AW +: AW]  = AW'(addr);
        return r;
    endfunction

    function automatic exp_t mk(input string tag, input int fa, input int fb,
                                input int st, input int fl, input int bz);
        exp_t e;
        e.tag = tag; e.fwda = fa; e.fwdb = fb; e.stall = st; e.flush = fl; e.busy = bz;
        return e;
    endfunction

    function automatic int stage_addr(input stim_t s, input int k);
        return int'((s.st_waddr >> ((k - 1) * AW)) % (1 << AW));
    endfunction

    // Youngest stage writing the source, 0 when none or the source is r0/unused.
    function automatic int model_fwd(input stim_t s, input logic used, input int src);
        if (!used || src == 0) return 0;
        for (int k = 1; k <= NFWD; k++)
            if (s.st_wreg[k-1] && stage_addr(s, k) == src) return k;
        return 0;
    endfunction

    function automatic int reads_reg(input logic used, input int src, input int r);
        return (used && src != 0 && src == r) ? 1 : 0;
    endfunction

    function automatic exp_t model_eval(input stim_t s);
        exp_t e;
        int   load_use;
        int   mdu_hz;
        int   s1_load_reg;
        s1_load_reg = (s.st_wreg[0] && s.st_mem2reg[0]) ? stage_addr(s, 1) : -1;
        load_use = reads_reg(s.rs_used, int'(s.rs), s1_load_reg) |
                   reads_reg(s.rt_used, int'(s.rt), s1_load_reg);
        mdu_hz = 0;
        if (m_busy_left > 0) begin
            if (s.mdu) mdu_hz = 1;
            if (m_pend_reg > 0) begin
                mdu_hz |= reads_reg(s.rs_used, int'(s.rs), m_pend_reg);
                mdu_hz |= reads_reg(s.rt_used, int'(s.rt), m_pend_reg);
                mdu_hz |= reads_reg(s.wreg, int'(s.waddr), m_pend_reg);
            end
        end
        e.tag   = "rand";
        e.fwda  = model_fwd(s, s.rs_used, int'(s.rs));
        e.fwdb  = model_fwd(s, s.rt_used, int'(s.rt));
        e.stall = (!s.rst && (load_use != 0 || mdu_hz != 0)) ? 1 : 0;
        e.flush = m_flush_due;
        e.busy  = (m_busy_left > 0) ? 1 : 0;
        return e;
    endfunction

    task automatic model_step(input stim_t s, input int stalled);
        if (s.rst) begin
            m_busy_left = 0;
            m_pend_reg  = -1;
            m_flush_due = 0;
        end else begin
            m_flush_due = (s.branch && s.taken && stalled == 0) ? 1 : 0;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) m_pend_reg = -1;
            end
            if (s.mdu && stalled == 0) begin
                m_busy_left = MDU_LAT;
                m_pend_reg  = (s.wreg && s.waddr != '0) ? int'(s.waddr) : -1;
            end
        end
    endtask

    task automatic drive(input stim_t s, input bit use_exp, input exp_t e);
        exp_t m;
        @(posedge clk);
        #1;
        rst            = s.rst;
        hif.id_rs      = s.rs;
        hif.id_rt      = s.rt;
        hif.id_rs_used = s.rs_used;
        hif.id_rt_used = s.rt_used;
        hif.id_wreg    = s.wreg;
        hif.id_waddr   = s.waddr;
        hif.id_mdu     = s.mdu;
        hif.id_branch  = s.branch;
        hif.id_taken   = s.taken;
        hif.st_wreg    = s.st_wreg;
        hif.st_mem2reg = s.st_mem2reg;
        hif.st_waddr   = s.st_waddr;
        m = model_eval(s);
        exp_q.push_back(use_exp ? e : m);
        model_step(s, m.stall);
    endtask

    task automatic dnop(input string tag, input int bz, input int fl);
        drive(nop(), 1'b1, mk(tag, 0, 0, 0, fl, bz));
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".fwda"},  8'(hif.fwda),     8'(e.fwda));
                check({e.tag, ".fwdb"},  8'(hif.fwdb),     8'(e.fwdb));
                check({e.tag, ".stall"}, 8'(hif.stall),    8'(e.stall));
                check({e.tag, ".flush"}, 8'(hif.flush),    8'(e.flush));
                check({e.tag, ".busy"},  8'(hif.mdu_busy), 8'(e.busy));
            end
        end
    end

    initial begin
        stim_t s;
        exp_t  none;
        none = mk("none", 0, 0, 0, 0, 0);

        rst = 1'b1;
        hif.id_rs = '0; hif.id_rt = '0; hif.id_rs_used = 1'b0; hif.id_rt_used = 1'b0;
        hif.id_wreg = 1'b0; hif.id_waddr = '0; hif.id_mdu = 1'b0;
        hif.id_branch = 1'b0; hif.id_taken = 1'b0;
        hif.st_wreg = '0; hif.st_mem2reg = '0; hif.st_waddr = '0;

        // Reset state.
        s = nop(); s.rst = 1'b1;
        drive(s, 1'b1, mk("reset0", 0, 0, 0, 0, 0));
        drive(s, 1'b1, mk("reset1", 0, 0, 0, 0, 0));

        // Stage 2 writes r5, add r6,r5,r5.
        s = with_stage(nop(), 2, 5, 1'b0);
        s.rs = 5; s.rt = 5; s.rs_used = 1; s.rt_used = 1; s.wreg = 1; s.waddr = 6;
        drive(s, 1'b1, mk("fwd_s2", 2, 2, 0, 0, 0));
        // Both stages write r5: youngest (stage 1) wins; rt=r7 stays on RF.
        s = with_stage(with_stage(nop(), 2, 5, 1'b0), 1, 5, 1'b0);
        s.rs = 5; s.rt = 7; s.rs_used = 1; s.rt_used = 1;
        drive(s, 1'b1, mk("fwd_prio", 1, 0, 0, 0, 0));

        // Load-use on rt only (rs matches too but is unused).
        s = with_stage(nop(), 1, 3, 1'b1);
        s.rs = 3; s.rt = 3; s.rt_used = 1;
        drive(s, 1'b1, mk("lu_stall", 0, 1, 1, 0, 0));
        s = with_stage(nop(), 2, 3, 1'b1);
        s.rs = 3; s.rt = 3; s.rt_used = 1;
        drive(s, 1'b1, mk("lu_after", 0, 2, 0, 0, 0));

        // Taken branch with no hazard, then an untaken one.
        s = nop(); s.branch = 1; s.taken = 1; s.rs = 1; s.rt = 2; s.rs_used = 1; s.rt_used = 1;
        drive(s, 1'b1, mk("br_taken", 0, 0, 0, 0, 0));
        dnop("br_flush", 0, 1);
        s = nop(); s.branch = 1; s.taken = 0; s.rs = 1; s.rs_used = 1;
        drive(s, 1'b1, mk("br_untaken", 0, 0, 0, 0, 0));
        dnop("br_noflush", 0, 0);

        // Taken branch behind a stage-1 load of its rs: stall, then flush.
        s = with_stage(nop(), 1, 4, 1'b1);
        s.branch = 1; s.taken = 1; s.rs = 4; s.rs_used = 1;
        drive(s, 1'b1, mk("brlu_stall", 1, 0, 1, 0, 0));
        s = with_stage(nop(), 2, 4, 1'b1);
        s.branch = 1; s.taken = 1; s.rs = 4; s.rs_used = 1;
        drive(s, 1'b1, mk("brlu_go", 2, 0, 0, 0, 0));
        dnop("brlu_flush", 0, 1);
        dnop("brlu_done", 0, 0);

        // mul r9, then a reader of r9 stalls for MDU_LAT cycles.
        s = nop(); s.mdu = 1; s.wreg = 1; s.waddr = 9;
        drive(s, 1'b1, mk("mul_issue", 0, 0, 0, 0, 0));
        s = nop(); s.rs = 9; s.rs_used = 1;
        for (int i = 0; i < MDU_LAT; i++) drive(s, 1'b1, mk("mul_raw", 0, 0, 1, 0, 1));
        drive(s, 1'b1, mk("mul_release", 0, 0, 0, 0, 0));

        // WAW on a pending destination, then a second MDU op while busy.
        s = nop(); s.mdu = 1; s.wreg = 1; s.waddr = 10;
        drive(s, 1'b1, mk("waw_issue", 0, 0, 0, 0, 0));
        s = nop(); s.wreg = 1; s.waddr = 10;
        drive(s, 1'b1, mk("waw_stall", 0, 0, 1, 0, 1));
        s = nop(); s.mdu = 1; s.wreg = 1; s.waddr = 11;
        drive(s, 1'b1, mk("mdu_struct", 0, 0, 1, 0, 1));
        for (int i = 0; i < MDU_LAT - 2; i++) dnop("waw_drain", 1, 0);
        dnop("waw_idle", 0, 0);

        // Register 0 never becomes pending nor causes a load-use stall.
        s = nop(); s.mdu = 1; s.wreg = 1; s.waddr = 0;
        drive(s, 1'b1, mk("r0_issue", 0, 0, 0, 0, 0));
        s = with_stage(nop(), 1, 0, 1'b1);
        s.rs_used = 1; s.rt_used = 1; s.wreg = 1; s.waddr = 0;
        drive(s, 1'b1, mk("r0_nohz", 0, 0, 0, 0, 1));
        for (int i = 0; i < MDU_LAT - 1; i++) dnop("r0_drain", 1, 0);
        dnop("r0_idle", 0, 0);

        // Reset on cycle 3 of an MDU op abandons it.
        s = nop(); s.mdu = 1; s.wreg = 1; s.waddr = 9;
        drive(s, 1'b1, mk("rstmdu_issue", 0, 0, 0, 0, 0));
        dnop("rstmdu_c1", 1, 0);
        dnop("rstmdu_c2", 1, 0);
        s = nop(); s.rst = 1; s.rs = 9; s.rs_used = 1;
        drive(s, 1'b1, mk("rstmdu_rst", 0, 0, 0, 0, 1));
        s = nop(); s.rs = 9; s.rs_used = 1;
        drive(s, 1'b1, mk("rstmdu_after", 0, 0, 0, 0, 0));
        drive(s, 1'b1, mk("rstmdu_after2", 0, 0, 0, 0, 0));

        // Randomized traffic against the model (small register range for matches).
        for (int n = 0; n < 2000; n++) begin
            s = nop();
            s.rst     = ($urandom_range(0, 63) == 0);
            s.rs      = AW'($urandom_range(0, 7));
            s.rt      = AW'($urandom_range(0, 7));
            s.rs_used = 1'($urandom_range(0, 1));
            s.rt_used = 1'($urandom_range(0, 1));
            s.wreg    = 1'($urandom_range(0, 1));
            s.waddr   = AW'($urandom_range(0, 7));
            s.mdu     = ($urandom_range(0, 4) == 0);
            s.branch  = ($urandom_range(0, 3) == 0);
            s.taken   = 1'($urandom_range(0, 1));
            for (int k = 0; k < NFWD; k++) begin
                s.st_wreg[k]            = 1'($urandom_range(0, 1));
                s.st_mem2reg[k]         = 1'($urandom_range(0, 1));
                s.st_waddr[k*AW +: AW]  = AW'($urandom_range(0, 7));
            end
            drive(s, 1'b0, none);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
